// File: rtl/stdout_uart_bridge_pkg.sv
// Shared types and defaults for the stdout-to-UART bridge.
// Holds the drain FSM state encoding and the default FIFO depth and busy timeout.
package stdout_uart_pkg;

    localparam int DEF_DEPTH        = 16;
    localparam int DEF_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/stdout_uart_bridge_if.sv
// Bundle of the processor-stdout side, the uart_tx handshake and the FIFO status.
// The master modport drives the processor and UART inputs; the slave modport is the bridge.
interface stdout_uart_bridge_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_tick;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       full;
    logic       empty;
    logic [AW:0] count;
    logic       overflow;

    modport master (
        output in_data, in_valid, in_tick, tx_ready,
        input  tx_data, tx_start, full, empty, count, overflow
    );

    modport slave (
        input  in_data, in_valid, in_tick, tx_ready,
        output tx_data, tx_start, full, empty, count, overflow
    );

endinterface

// File: rtl/stdout_uart_bridge_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module sync_fifo
    import stdout_uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_nxt;

    assign w_do_pop  = i_pop & ~r_empty;
    assign w_do_push = i_push & (~r_full | w_do_pop);

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and flags; flags come from the next count so they stay coherent with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == L_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/stdout_uart_bridge.sv
// Buffers processor stdout bytes and feeds them one at a time to uart_tx.
// Each processor cycle is qualified by in_tick so a level-held stdout_en yields one byte.
module stdout_uart_bridge
    import stdout_uart_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rstn,
    stdout_uart_bridge_if.slave  io_bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TW-1:0]   r_to_cnt;
    logic [TW-1:0]   w_to_cnt_nxt;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_overflow;
    logic            w_push_req;
    logic            w_pop;
    logic            w_drop;
    logic [7:0]      w_rd_data;
    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_count;

    assign w_push_req = io_bus.in_tick & io_bus.in_valid;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty & io_bus.tx_ready;
    assign w_drop     = w_push_req & w_full & ~w_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push_req),
        .i_wdata (io_bus.in_data),
        .i_pop   (w_pop),
        .o_rdata (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Drain FSM next state; a UART that never drops ready releases the byte after the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt  = ST_WAIT_BUSY;
                w_to_cnt_nxt = '0;
            end
            ST_WAIT_BUSY: begin
                if (!io_bus.tx_ready) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (io_bus.tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_to_cnt_nxt = '0;
            end
        endcase
    end

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Start pulse is registered on the pop edge, so it is high exactly during START.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign io_bus.tx_data  = r_tx_data;
    assign io_bus.tx_start = r_tx_start;
    assign io_bus.overflow = r_overflow;
    assign io_bus.full     = w_full;
    assign io_bus.empty    = w_empty;
    assign io_bus.count    = w_count;

endmodule

// File: tb/tb_stdout_uart_bridge.sv
// Bench for stdout_uart_bridge: queue-based byte model, a simple uart_tx model,
// directed scenarios with literal expectations and a randomized phase.
module tb_stdout_uart_bridge;

    localparam int DEPTH = 16;
    localparam int BT    = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    stdout_uart_bridge_if #(.DEPTH(DEPTH)) bus ();

    stdout_uart_bridge #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .io_bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart_tx model: mode 0 = busy for busy_len cycles after a start, 1 = ready stuck high, 2 = ready held low
    int uart_mode = 0;
    int busy_len  = 10;
    int busy_cnt  = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            busy_cnt     = 0;
            bus.tx_ready = (uart_mode != 2);
        end else if (uart_mode == 2) begin
            bus.tx_ready = 1'b0;
        end else if (uart_mode == 1) begin
            bus.tx_ready = 1'b1;
        end else if (bus.tx_start) begin
            busy_cnt     = busy_len;
            bus.tx_ready = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt     = busy_cnt - 1;
            bus.tx_ready = (busy_cnt == 0);
        end else begin
            bus.tx_ready = 1'b1;
        end
    end

    // Byte-level model: FIFO of accepted bytes, sticky drop flag, log of delivered bytes
    logic [7:0] q[$];
    logic [7:0] sent[$];
    int         starts[$];
    logic [7:0] m_last;
    logic       m_ovf;
    logic       p_push, p_rdy, prev_start;
    logic [7:0] p_data, exp_b;
    int         stall = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         dut_peak = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            q.delete();
            m_ovf      = 1'b0;
            m_last     = 8'h00;
            stall      = 0;
            prev_start = 1'b0;
        end else begin
            p_push = bus.in_tick & bus.in_valid;
            p_data = bus.in_data;
            p_rdy  = bus.tx_ready;
            #1;
            if (bus.tx_start) begin
                start_cnt++;
                starts.push_back(cyc);
                chk("start_single_cycle", int'(prev_start), 0);
                chk("pop_needs_ready", int'(p_rdy), 1);
                chk("pop_needs_data", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_b = q.pop_front();
                    chk("tx_data", int'(bus.tx_data), int'(exp_b));
                    m_last = exp_b;
                    sent.push_back(exp_b);
                end
            end else begin
                chk("tx_data_hold", int'(bus.tx_data), int'(m_last));
            end
            if (p_push) begin
                if (q.size() < DEPTH) q.push_back(p_data);
                else m_ovf = 1'b1;
            end
            chk("count", int'(bus.count), q.size());
            chk("full", int'(bus.full), int'(q.size() == DEPTH));
            chk("empty", int'(bus.empty), int'(q.size() == 0));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            if (int'(bus.count) > dut_peak) dut_peak = int'(bus.count);
            if (q.size() != 0 && p_rdy && !bus.tx_start) stall++;
            else stall = 0;
            if (stall > BT + 2) begin
                chk("drain_stalled", stall, BT + 2);
                stall = 0;
            end
            prev_start = bus.tx_start;
        end
    end

    task automatic tick_push(input logic [7:0] d, input int gap);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_tick  = 1'b1;
        @(negedge clk);
        bus.in_tick  = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || bus.tx_ready !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (BT + 4) @(negedge clk);
        chk({name, "_drain_done"}, int'(n < 3000), 1);
    endtask

    int n0, k0, t1, t2, t3, ns;

    initial begin
        rstn = 1'b0;
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_start", int'(bus.tx_start), 0);
        chk("rst_tx_data", int'(bus.tx_data), 32'h00);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        @(negedge clk); rstn = 1'b1;
        repeat (3) @(negedge clk);

        // single byte: start pulse during the cycle after the edge following the push
        @(negedge clk);
        bus.in_data = 8'h48; bus.in_valid = 1'b1; bus.in_tick = 1'b1;
        @(posedge clk); #1;
        chk("lat_push_edge_start", int'(bus.tx_start), 0);
        chk("lat_push_edge_count", int'(bus.count), 1);
        @(negedge clk); bus.in_tick = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_pop_edge_start", int'(bus.tx_start), 1);
        chk("lat_pop_edge_data", int'(bus.tx_data), 32'h48);
        chk("lat_pop_edge_count", int'(bus.count), 0);
        @(posedge clk); #1;
        chk("lat_pulse_width", int'(bus.tx_start), 0);
        drain("single");

        // reset while the UART is busy on a byte
        busy_len = 40;
        tick_push(8'h48, 0);
        ns = 0;
        do begin @(posedge clk); #1; ns++; end while (!bus.tx_start && ns < 20);
        chk("rstmid_start_seen", int'(bus.tx_start), 1);
        repeat (6) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rstmid_tx_start", int'(bus.tx_start), 0);
        chk("rstmid_tx_data", int'(bus.tx_data), 32'h00);
        chk("rstmid_count", int'(bus.count), 0);
        chk("rstmid_empty", int'(bus.empty), 1);
        k0 = start_cnt;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("rstmid_no_resend", start_cnt - k0, 0);

        // level-held in_valid with three ticks
        busy_len = 10;
        n0 = sent.size();
        t1 = $urandom_range(10, 300); t2 = t1 + 330; t3 = t2 + 330;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h41;
        for (int c = 0; c < 1000; c++) begin
            bus.in_tick = (c == t1 || c == t2 || c == t3);
            @(negedge clk);
        end
        bus.in_tick = 1'b0; bus.in_valid = 1'b0;
        drain("level");
        chk("level_bytes", sent.size() - n0, 3);
        for (int i = 0; i < 3; i++)
            if (n0 + i < sent.size()) chk("level_value", int'(sent[n0 + i]), 32'h41);

        // burst while the UART is busy
        n0 = sent.size();
        dut_peak = 0;
        for (int i = 1; i <= 5; i++) tick_push(8'(i), 1);
        drain("burst");
        chk("burst_bytes", sent.size() - n0, 5);
        for (int i = 0; i < 5; i++)
            if (n0 + i < sent.size()) chk("burst_order", int'(sent[n0 + i]), i + 1);
        chk("burst_peak", dut_peak, 4);
        chk("burst_no_overflow", int'(bus.overflow), 0);

        // fill past full with the UART held not-ready
        uart_mode = 2;
        repeat (3) @(negedge clk);
        n0 = sent.size();
        for (int i = 0; i <= 16; i++) tick_push(8'(i), 0);
        @(posedge clk); #1;
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 16);
        chk("fill_overflow", int'(bus.overflow), 1);
        uart_mode = 0; busy_len = 3;
        drain("fill");
        chk("fill_drained", sent.size() - n0, 16);
        for (int i = 0; i < 16; i++)
            if (n0 + i < sent.size()) chk("fill_order", int'(sent[n0 + i]), i);

        // pointer wrap
        n0 = sent.size();
        for (int i = 0; i < 20; i++) tick_push(8'(8'h80 + i), $urandom_range(0, 6));
        drain("wrap");
        chk("wrap_bytes", sent.size() - n0, 20);
        for (int i = 0; i < 20; i++)
            if (n0 + i < sent.size()) chk("wrap_order", int'(sent[n0 + i]), 32'h80 + i);

        // ready stuck high: release after the timeout, start pulses BT+2 cycles apart
        uart_mode = 1;
        repeat (3) @(negedge clk);
        k0 = starts.size();
        tick_push(8'h61, 0); tick_push(8'h62, 0); tick_push(8'h63, 0);
        drain("timeout");
        chk("timeout_pulses", starts.size() - k0, 3);
        if (starts.size() - k0 == 3) begin
            chk("timeout_gap1", starts[k0 + 1] - starts[k0], BT + 2);
            chk("timeout_gap2", starts[k0 + 2] - starts[k0 + 1], BT + 2);
        end

        // full FIFO: push coincident with pop is accepted
        uart_mode = 2;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        n0 = sent.size();
        for (int i = 0; i < 16; i++) tick_push(8'(8'hC0 + i), 0);
        chk("simul_pre_full", int'(bus.full), 1);
        chk("simul_pre_overflow", int'(bus.overflow), 0);
        @(posedge clk); #2;
        uart_mode = 1;
        @(negedge clk);
        bus.in_data = 8'hAA; bus.in_valid = 1'b1; bus.in_tick = 1'b1;
        @(posedge clk); #1;
        chk("simul_start", int'(bus.tx_start), 1);
        chk("simul_count", int'(bus.count), 16);
        chk("simul_full", int'(bus.full), 1);
        chk("simul_overflow", int'(bus.overflow), 0);
        @(negedge clk); bus.in_tick = 1'b0; bus.in_valid = 1'b0;
        drain("simul");
        chk("simul_bytes", sent.size() - n0, 17);
        if (sent.size() - n0 == 17) chk("simul_last", int'(sent[n0 + 16]), 32'hAA);

        // randomized traffic with varying UART behaviour
        uart_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 50 == 0) busy_len = $urandom_range(2, 20);
            if (c % 400 == 200) uart_mode = $urandom_range(0, 2);
            bus.in_tick  = ($urandom_range(0, 3) == 0);
            bus.in_valid = ($urandom_range(0, 4) != 0);
            bus.in_data  = 8'($urandom);
        end
        bus.in_tick = 1'b0; bus.in_valid = 1'b0;
        uart_mode = 0;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
